// File: rtl/video_window_fit_if.sv
// Raw core video in, windowed video and source measurements out.
// The driver of the raw stream holds master; the window stage holds slave.
interface video_window_fit_if #(
   parameter int DW = 8
);
   logic          ce;
   logic [DW-1:0] video_in;
   logic          hblank;
   logic          vblank;
   logic          hsync;
   logic          vsync;
   logic [9:0]    x_off;
   logic [8:0]    y_off;

   logic          ce_out;
   logic [DW-1:0] video_out;
   logic          hblank_out;
   logic          vblank_out;
   logic          hsync_out;
   logic          vsync_out;
   logic [9:0]    meas_width;
   logic [8:0]    meas_height;
   logic          meas_valid;

   modport master (
      output ce, video_in, hblank, vblank, hsync, vsync, x_off, y_off,
      input  ce_out, video_out, hblank_out, vblank_out, hsync_out, vsync_out,
             meas_width, meas_height, meas_valid
   );

   modport slave (
      input  ce, video_in, hblank, vblank, hsync, vsync, x_off, y_off,
      output ce_out, video_out, hblank_out, vblank_out, hsync_out, vsync_out,
             meas_width, meas_height, meas_valid
   );
endinterface

// File: rtl/video_window_fit.sv
// Crops raw core video to a WIDTH x HEIGHT window with one clock of latency
// and reports the widest line / line count of the last complete source frame.
module video_window_fit #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int DW     = 8
) (
   input logic               clk,
   input logic               reset_n,
   video_window_fit_if.slave vif
);
   localparam logic [DW-1:0] BLACK = '0;
   localparam logic [10:0]   W11   = 11'(WIDTH);
   localparam logic [10:0]   H11   = 11'(HEIGHT);

   logic [9:0]  x_cnt, xo, frame_max;
   logic [8:0]  y_cnt, yo;
   logic        old_hblank, old_vblank, frame_seen;

   logic        h_rise, v_rise, line_end;
   logic        hwin, vwin, hb_next, vb_next;
   logic [9:0]  x_inc, width_max;
   logic [8:0]  y_inc;
   logic [10:0] x_end, y_end;

   always_comb begin
      h_rise    = ~old_hblank & vif.hblank;
      v_rise    = ~old_vblank & vif.vblank;
      // a line still ends when hblank and vblank rise together
      line_end  = h_rise & (~vif.vblank | v_rise);
      x_inc     = (&x_cnt) ? x_cnt : x_cnt + 10'd1;
      y_inc     = (&y_cnt) ? y_cnt : y_cnt + 9'd1;
      width_max = (x_cnt > frame_max) ? x_cnt : frame_max;
      // 11-bit bounds so a window running past the source end never wraps
      x_end     = {1'b0, xo} + W11;
      y_end     = {2'b00, yo} + H11;
      hwin      = ({1'b0, x_cnt} >= {1'b0, xo}) & ({1'b0, x_cnt} < x_end);
      vwin      = ({2'b00, y_cnt} >= {2'b00, yo}) & ({2'b00, y_cnt} < y_end);
      hb_next   = vif.hblank | ~hwin;
      vb_next   = vif.vblank | ~vwin;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vif.ce_out <= 1'b0;
      else          vif.ce_out <= vif.ce;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vif.video_out   <= BLACK;
         vif.hblank_out  <= 1'b1;
         vif.vblank_out  <= 1'b1;
         vif.hsync_out   <= 1'b0;
         vif.vsync_out   <= 1'b0;
         vif.meas_width  <= '0;
         vif.meas_height <= '0;
         vif.meas_valid  <= 1'b0;
         x_cnt           <= '0;
         y_cnt           <= '0;
         xo              <= '0;
         yo              <= '0;
         frame_max       <= '0;
         old_hblank      <= 1'b0;
         old_vblank      <= 1'b0;
         frame_seen      <= 1'b0;
      end else if (vif.ce) begin
         vif.hblank_out <= hb_next;
         vif.vblank_out <= vb_next;
         vif.video_out  <= (~hb_next & ~vb_next) ? vif.video_in : BLACK;
         vif.hsync_out  <= vif.hsync;
         vif.vsync_out  <= vif.vsync;
         old_hblank     <= vif.hblank;
         old_vblank     <= vif.vblank;

         if (vif.hblank)       x_cnt <= '0;
         else if (!vif.vblank) x_cnt <= x_inc;

         if (v_rise) begin
            y_cnt      <= '0;
            frame_max  <= '0;
            xo         <= vif.x_off;
            yo         <= vif.y_off;
            frame_seen <= 1'b1;
            // the first frame after reset is partial, so it only arms reporting
            if (frame_seen) begin
               vif.meas_width  <= line_end ? width_max : frame_max;
               vif.meas_height <= line_end ? y_inc : y_cnt;
               vif.meas_valid  <= 1'b1;
            end
         end else if (line_end) begin
            y_cnt     <= y_inc;
            frame_max <= width_max;
         end
      end
   end
endmodule

// File: tb/tb_video_window_fit.sv
// Directed bench for video_window_fit: a frame-level model predicts every
// output beat; literal pins check window corners, pixel counts and measurements.
module tb_video_window_fit;
   localparam int W  = 20;
   localparam int H  = 12;
   localparam int HB = 4;

   typedef struct {
      logic [7:0] vid;
      logic       hb, vb, hs, vs, mv;
      logic [9:0] mw;
      logic [8:0] mh;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   video_window_fit_if #(.DW(8)) bus ();
   video_window_fit #(.WIDTH(W), .HEIGHT(H), .DW(8)) dut (
      .clk(clk), .reset_n(reset_n), .vif(bus)
   );

   int   n_tot = 0, n_bad = 0;
   exp_t q[$];
   exp_t last_e, cur;
   logic exp_ce_q = 1'b0;

   // frame-level model state
   int m_xo, m_yo, fw, fh, em_w, em_h;
   bit seen, m_old_v, em_valid;

   // capture of active output beats for literal pins
   int         cap_n;
   bit         cap_have;
   logic [7:0] cap_first, cap_last;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pix(input int x, input int y);
      return 8'((x * 7 + y * 13) & 255);
   endfunction

   function automatic bit win(input int c, input int o, input int n);
      return (c >= o) && (c < o + n);
   endfunction

   task automatic m_reset();
      q.delete();
      m_xo = 0; m_yo = 0; fw = 0; fh = 0;
      seen = 0; m_old_v = 0; em_valid = 0; em_w = 0; em_h = 0;
      last_e = '{vid: 8'd0, hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0,
                 mv: 1'b0, mw: 10'd0, mh: 9'd0};
   endtask

   task automatic cap_clear();
      cap_n = 0; cap_have = 0; cap_first = 0; cap_last = 0;
   endtask

   // one source beat; called at posedge+1, returns at posedge+1 after it is taken
   task automatic send(input bit h, input bit v, input bit hs, input bit vs,
                       input logic [7:0] d, input bit ehb, input bit evb, input int gap);
      exp_t e;
      if (v && !m_old_v) begin
         if (seen) begin em_valid = 1; em_w = fw; em_h = fh; end
         seen = 1; fw = 0; fh = 0;
         m_xo = int'(bus.x_off); m_yo = int'(bus.y_off);
      end
      m_old_v = v;
      e.vid = (!ehb && !evb) ? d : 8'd0;
      e.hb = ehb; e.vb = evb; e.hs = hs; e.vs = vs;
      e.mv = em_valid; e.mw = 10'(em_w); e.mh = 9'(em_h);
      q.push_back(e);
      bus.ce = 1'b1; bus.hblank = h; bus.vblank = v;
      bus.hsync = hs; bus.vsync = vs; bus.video_in = d;
      @(posedge clk); #1;
      bus.ce = 1'b0;
      repeat (gap) begin
         bus.video_in = 8'($urandom);
         bus.hsync = 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic vb_region();
      for (int i = 0; i < 20; i++)
         send(1, 1, (i % 8) < 2, (i >= 5 && i < 11), 8'($urandom), 1, 1, 0);
   endtask

   task automatic frame(input int w, input int h, input int gap, input int last_w,
                        input bit sim_last, input int xchg_line, input int xchg_val);
      for (int y = 0; y < h; y++) begin
         int lw;
         lw = (y == h - 1 && last_w > 0) ? last_w : w;
         if (y == xchg_line) bus.x_off = 10'(xchg_val);
         for (int x = 0; x < lw; x++)
            send(0, 0, 0, 0, pix(x, y), !win(x, m_xo, W), !win(y, m_yo, H), gap);
         fh++;
         if (lw > fw) fw = lw;
         // a blank beat after the first one already belongs to the next line
         if (!(sim_last && y == h - 1))
            for (int k = 0; k < HB; k++)
               send(1, 0, (k == 1 || k == 2), 0, 8'($urandom), 1,
                    !win((k == 0) ? y : y + 1, m_yo, H), gap);
      end
   endtask

   task automatic drain();
      @(negedge clk); #1;
   endtask

   always @(posedge clk) exp_ce_q <= reset_n ? bus.ce : 1'b0;

   always @(negedge clk) begin
      if (reset_n) begin
         chk("ce_out", bus.ce_out, exp_ce_q);
         if (bus.ce_out) begin
            if (q.size() == 0) chk("beat_expected", 0, 1);
            else begin
               cur = q.pop_front();
               last_e = cur;
            end
            if (!bus.hblank_out && !bus.vblank_out) begin
               cap_n++;
               if (!cap_have) begin cap_first = bus.video_out; cap_have = 1; end
               cap_last = bus.video_out;
            end
         end
         chk("video_out", bus.video_out, last_e.vid);
         chk("hblank_out", bus.hblank_out, last_e.hb);
         chk("vblank_out", bus.vblank_out, last_e.vb);
         chk("hsync_out", bus.hsync_out, last_e.hs);
         chk("vsync_out", bus.vsync_out, last_e.vs);
         chk("meas_valid", bus.meas_valid, last_e.mv);
         chk("meas_width", bus.meas_width, last_e.mw);
         chk("meas_height", bus.meas_height, last_e.mh);
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_video"}, bus.video_out, 0);
      chk({tag, "_ce_out"}, bus.ce_out, 0);
      chk({tag, "_hblank"}, bus.hblank_out, 1);
      chk({tag, "_vblank"}, bus.vblank_out, 1);
      chk({tag, "_hsync"}, bus.hsync_out, 0);
      chk({tag, "_vsync"}, bus.vsync_out, 0);
      chk({tag, "_mvalid"}, bus.meas_valid, 0);
      chk({tag, "_mwidth"}, bus.meas_width, 0);
      chk({tag, "_mheight"}, bus.meas_height, 0);
   endtask

   task automatic chk_meas(input string tag, input int w, input int h, input int v);
      chk({tag, "_mwidth"}, bus.meas_width, w);
      chk({tag, "_mheight"}, bus.meas_height, h);
      chk({tag, "_mvalid"}, bus.meas_valid, v);
   endtask

   initial begin
      bus.ce = 0; bus.hblank = 1; bus.vblank = 1; bus.hsync = 0; bus.vsync = 0;
      bus.video_in = 0; bus.x_off = 10'd2; bus.y_off = 9'd1;
      reset_n = 0;
      m_reset();
      cap_clear();
      @(negedge clk); #1;
      chk_reset_vals("rst");
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      @(posedge clk); #1;

      // 24x16 source, window 20x12 at (2,1)
      vb_region();
      cap_clear();
      frame(24, 16, 0, 0, 0, -1, 0);
      drain();
      chk("a_count", cap_n, 240);
      chk("a_first", cap_first, 27);
      chk("a_last", cap_last, 47);
      bus.x_off = 0; bus.y_off = 0;
      vb_region();
      drain();
      chk_meas("a", 24, 16, 1);

      // short 18x10 source: no padding to the window size
      cap_clear();
      frame(18, 10, 0, 0, 0, -1, 0);
      drain();
      chk("b_count", cap_n, 180);
      chk("b_last", cap_last, 236);
      bus.x_off = 0; bus.y_off = 1;
      vb_region();
      drain();
      chk_meas("b", 18, 10, 1);

      // x_off changed mid-frame takes effect only after the next vblank rise
      cap_clear();
      frame(24, 16, 0, 0, 0, 5, 4);
      drain();
      chk("c1_count", cap_n, 240);
      chk("c1_first", cap_first, 13);
      vb_region();
      cap_clear();
      frame(24, 16, 0, 0, 0, -1, 0);
      drain();
      chk("c2_count", cap_n, 240);
      chk("c2_first", cap_first, 41);
      vb_region();

      // ce every 4th clock
      cap_clear();
      frame(24, 16, 3, 0, 0, -1, 0);
      drain();
      chk("d_count", cap_n, 240);
      chk("d_first", cap_first, 41);
      chk("d_last", cap_last, 61);
      bus.x_off = 0; bus.y_off = 0;
      vb_region();

      // last line 390 wide with hblank and vblank rising together
      cap_clear();
      frame(10, 4, 0, 390, 1, -1, 0);
      vb_region();
      drain();
      chk("e_count", cap_n, 50);
      chk_meas("e", 390, 4, 1);

      // reset in the middle of active video
      bus.x_off = 3;
      frame(24, 4, 0, 0, 0, -1, 0);
      for (int x = 0; x < 6; x++)
         send(0, 0, 0, 0, pix(x, 4), !win(x, m_xo, W), !win(4, m_yo, H), 0);
      #2 reset_n = 0;
      bus.ce = 0; bus.hblank = 0; bus.vblank = 0;
      #1;
      chk_reset_vals("midrst");
      m_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      cap_clear();
      frame(24, 8, 0, 0, 0, -1, 0);
      drain();
      chk("f1_count", cap_n, 160);
      vb_region();
      drain();
      chk("f_arm_mvalid", bus.meas_valid, 0);
      cap_clear();
      frame(24, 8, 0, 0, 0, -1, 0);
      drain();
      chk("f2_count", cap_n, 160);
      chk("f2_first", cap_first, 21);
      vb_region();
      drain();
      chk_meas("f", 24, 8, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
